// File: rtl/dtfag_idx_seq_if.sv
// -----------------------------------------------------------------------------
// dtfag_idx_seq_if
// Index tuple stream between the DTFAG index sequencer (master) and the
// combinational AGU / twiddle-memory read path (slave).
//
// Signals
//   out_valid   master -> slave  tuple fields hold a valid tuple
//   out_ready   slave  -> master slave accepts the current tuple this cycle
//   DTFAG_i     master -> slave  outer index digit
//   DTFAG_t     master -> slave  middle index digit
//   DTFAG_j     master -> slave  inner (fastest) index digit
//   stage_idx   master -> slave  current FFT stage
//   stage_last  master -> slave  current tuple is the last one of its stage
// -----------------------------------------------------------------------------
interface dtfag_idx_seq_if #(
    parameter int RADIX_W = 4,
    parameter int STAGE_W = 2
);
    logic               out_valid;
    logic               out_ready;
    logic [RADIX_W-1:0] DTFAG_i;
    logic [RADIX_W-1:0] DTFAG_t;
    logic [RADIX_W-1:0] DTFAG_j;
    logic [STAGE_W-1:0] stage_idx;
    logic               stage_last;

    modport master (
        output out_valid,
        output DTFAG_i,
        output DTFAG_t,
        output DTFAG_j,
        output stage_idx,
        output stage_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  DTFAG_i,
        input  DTFAG_t,
        input  DTFAG_j,
        input  stage_idx,
        input  stage_last,
        output out_ready
    );
endinterface

// File: rtl/dtfag_idx_seq.sv
// -----------------------------------------------------------------------------
// dtfag_idx_seq
// Index sequencer for the DTFAG address generator. A start pulse launches one
// full transform: for every stage it emits every (i, t, j) radix-2**RADIX_W
// index tuple in odometer order (j fastest, then t, then i, then stage) over a
// valid/ready stream. After the final tuple is accepted, done pulses for one
// cycle and the block returns to idle.
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   synchronous reset, active-high, wins over everything
//   start  in   one-cycle request to begin a transform; ignored unless idle
//   idx    master modport of dtfag_idx_seq_if (tuple stream)
//   busy   out  high while a transform is in progress (RUN and DONE)
//   done   out  one-cycle pulse after the final tuple is accepted
// -----------------------------------------------------------------------------
module dtfag_idx_seq #(
    parameter int RADIX_W   = 4,
    parameter int NUM_STAGE = 4,
    parameter int STAGE_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    dtfag_idx_seq_if.master         idx,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [RADIX_W-1:0] DIGIT_MAX = '1;
    localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(NUM_STAGE - 1);

    state_t             state_q, state_d;
    logic [RADIX_W-1:0] i_q, i_d;
    logic [RADIX_W-1:0] t_q, t_d;
    logic [RADIX_W-1:0] j_q, j_d;
    logic [STAGE_W-1:0] stage_q, stage_d;

    logic accept;
    logic j_wrap, t_wrap, i_wrap;
    logic last_tuple;

    // Next-state and odometer logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        i_d     = i_q;
        t_d     = t_q;
        j_d     = j_q;
        stage_d = stage_q;

        accept     = (state_q == RUN) && idx.out_ready;
        j_wrap     = (j_q == DIGIT_MAX);
        t_wrap     = (t_q == DIGIT_MAX);
        i_wrap     = (i_q == DIGIT_MAX);
        last_tuple = j_wrap && t_wrap && i_wrap && (stage_q == STAGE_MAX);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    t_d     = '0;
                    j_d     = '0;
                    stage_d = '0;
                end
            end
            RUN: begin
                // Tuple fields only move on accept; a stall holds everything.
                if (accept) begin
                    if (last_tuple) begin
                        state_d = DONE;
                        i_d     = '0;
                        t_d     = '0;
                        j_d     = '0;
                        stage_d = '0;
                    end else begin
                        j_d = j_q + RADIX_W'(1);
                        if (j_wrap) begin
                            t_d = t_q + RADIX_W'(1);
                            if (t_wrap) begin
                                i_d = i_q + RADIX_W'(1);
                                if (i_wrap) begin
                                    stage_d = stage_q + STAGE_W'(1);
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here: no queuing.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            t_q     <= '0;
            j_q     <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            t_q     <= t_d;
            j_q     <= j_d;
            stage_q <= stage_d;
        end
    end

    // out_valid is a pure state decode, so there are no bubbles inside a run.
    assign idx.out_valid  = (state_q == RUN);
    assign idx.DTFAG_i    = i_q;
    assign idx.DTFAG_t    = t_q;
    assign idx.DTFAG_j    = j_q;
    assign idx.stage_idx  = stage_q;
    assign idx.stage_last = (state_q == RUN) && j_wrap && t_wrap && i_wrap;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_dtfag_idx_seq.sv
// -----------------------------------------------------------------------------
// tb_dtfag_idx_seq
// Self-checking bench for dtfag_idx_seq. Each start pushes the full expected
// tuple sequence onto a scoreboard queue; tuples are popped and compared as
// the DUT presents them and they are accepted. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_dtfag_idx_seq;

    localparam int RADIX_W   = 4;
    localparam int NUM_STAGE = 4;
    localparam int STAGE_W   = 2;
    localparam int DIGITS    = 1 << RADIX_W;
    localparam int PER_STAGE = DIGITS * DIGITS * DIGITS;
    localparam int TOTAL     = NUM_STAGE * PER_STAGE;
    localparam int BUDGET    = 4 * TOTAL;
    localparam int MAX_FAILS = 20;

    typedef struct packed {
        logic [STAGE_W-1:0] s;
        logic [RADIX_W-1:0] i;
        logic [RADIX_W-1:0] t;
        logic [RADIX_W-1:0] j;
    } tuple_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    dtfag_idx_seq_if #(.RADIX_W(RADIX_W), .STAGE_W(STAGE_W)) idx_bus ();

    dtfag_idx_seq #(
        .RADIX_W   (RADIX_W),
        .NUM_STAGE (NUM_STAGE),
        .STAGE_W   (STAGE_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .idx   (idx_bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    tuple_t sb_q[$];
    int     vectors     = 0;
    int     miscompares = 0;

    function automatic tuple_t observed();
        tuple_t o;
        o.s = idx_bus.stage_idx;
        o.i = idx_bus.DTFAG_i;
        o.t = idx_bus.DTFAG_t;
        o.j = idx_bus.DTFAG_j;
        return o;
    endfunction

    // Tuple number n of a run, decoded as a mixed-radix number.
    function automatic tuple_t model_tuple(input int n);
        tuple_t m;
        m.s = STAGE_W'(n / PER_STAGE);
        m.i = RADIX_W'((n / (DIGITS * DIGITS)) % DIGITS);
        m.t = RADIX_W'((n / DIGITS) % DIGITS);
        m.j = RADIX_W'(n % DIGITS);
        return m;
    endfunction

    task automatic push_run();
        sb_q.delete();
        for (int n = 0; n < TOTAL; n++) sb_q.push_back(model_tuple(n));
    endtask

    // Runs one full transform with the given ready probability, optionally
    // pulsing start at cycle stray_cyc and in the DONE cycle.
    task automatic run_stream(input string name, input int ready_pct,
                              input int stray_cyc, input bit start_in_done);
        int     cyc;
        int     last_pop;
        bit     finished;
        bit     prev_stall;
        bit     rdy;
        tuple_t prev;
        tuple_t exp_t;
        logic   exp_last;

        push_run();
        cyc        = 0;
        last_pop   = -10;
        finished   = 1'b0;
        prev_stall = 1'b0;
        prev       = '0;

        @(negedge clk);
        start             = 1'b1;
        idx_bus.out_ready = 1'b0;

        while (!finished) begin
            @(negedge clk);
            cyc++;
            start = (cyc == stray_cyc);

            if (cyc > BUDGET) begin
                miscompares++;
                $display("FAIL %s timeout: cycle %0d, %0d tuples still expected", name, cyc, sb_q.size());
                break;
            end
            if (miscompares > MAX_FAILS) begin
                $display("FAIL %s aborted after %0d miscompares", name, miscompares);
                break;
            end

            if (prev_stall) begin
                vectors++;
                if (observed() !== prev || idx_bus.out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s stall_hold cyc %0d: got %h valid %b, need %h valid 1",
                             name, cyc, observed(), idx_bus.out_valid, prev);
                end
            end

            if (sb_q.size() > 0) begin
                exp_t    = sb_q[0];
                exp_last = (exp_t.i == RADIX_W'(DIGITS - 1)) && (exp_t.t == RADIX_W'(DIGITS - 1))
                           && (exp_t.j == RADIX_W'(DIGITS - 1));

                vectors++;
                if (idx_bus.out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s run_flags cyc %0d: valid %b busy %b done %b, need 1 1 0",
                             name, cyc, idx_bus.out_valid, busy, done);
                end
                vectors++;
                if (observed() !== exp_t) begin
                    miscompares++;
                    $display("FAIL %s tuple cyc %0d: got s%0d (%0d,%0d,%0d), need s%0d (%0d,%0d,%0d)",
                             name, cyc, idx_bus.stage_idx, idx_bus.DTFAG_i, idx_bus.DTFAG_t,
                             idx_bus.DTFAG_j, exp_t.s, exp_t.i, exp_t.t, exp_t.j);
                end
                vectors++;
                if (idx_bus.stage_last !== exp_last) begin
                    miscompares++;
                    $display("FAIL %s stage_last cyc %0d: got %b, need %b", name, cyc,
                             idx_bus.stage_last, exp_last);
                end

                rdy               = ($urandom_range(99) < ready_pct);
                idx_bus.out_ready = rdy;
                prev_stall        = !rdy;
                prev              = observed();
                if (rdy) begin
                    void'(sb_q.pop_front());
                    last_pop = cyc;
                end
            end else begin
                prev_stall        = 1'b0;
                idx_bus.out_ready = 1'($urandom_range(1));
                vectors++;
                if (cyc == last_pop + 1) begin
                    if (done !== 1'b1 || busy !== 1'b1 || idx_bus.out_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s done_pulse cyc %0d: done %b busy %b valid %b, need 1 1 0",
                                 name, cyc, done, busy, idx_bus.out_valid);
                    end
                    if (start_in_done) start = 1'b1;
                end else begin
                    if (done !== 1'b0 || busy !== 1'b0 || idx_bus.out_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s idle_after cyc %0d: done %b busy %b valid %b, need 0 0 0",
                                 name, cyc, done, busy, idx_bus.out_valid);
                    end
                    if (cyc >= last_pop + 5) finished = 1'b1;
                end
            end
        end

        start             = 1'b0;
        idx_bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        start             = 1'b0;
        idx_bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (idx_bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || idx_bus.stage_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: valid %b busy %b done %b last %b, need all 0",
                     idx_bus.out_valid, busy, done, idx_bus.stage_last);
        end
        vectors++;
        if (observed() !== tuple_t'(0)) begin
            miscompares++;
            $display("FAIL reset_indices: got %h, need 0", observed());
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || idx_bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy %b valid %b, need 0 0", busy, idx_bus.out_valid);
        end
    endtask

    task automatic test_basic();
        run_stream("basic", 100, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 50, -1, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_stream("ignored_start", 100, 100, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        tuple_t target;
        bit     found;

        target   = '{s: 2'd1, i: 4'd3, t: 4'd7, j: 4'd9};
        found    = 1'b0;
        @(negedge clk);
        start             = 1'b1;
        idx_bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2 * PER_STAGE; c++) begin
            if (idx_bus.out_valid === 1'b1 && observed() === target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midrun_reach: tuple %h not seen, last %h", target, observed());
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (idx_bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || observed() !== tuple_t'(0)) begin
            miscompares++;
            $display("FAIL midrun_reset: valid %b busy %b done %b idx %h, need 0 0 0 0",
                     idx_bus.out_valid, busy, done, observed());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || idx_bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrun_no_done: done %b valid %b, need 0 0", done, idx_bus.out_valid);
            end
        end

        // Fresh start must begin again from tuple zero.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (idx_bus.out_valid !== 1'b1 || observed() !== model_tuple(n)) begin
                miscompares++;
                $display("FAIL restart_tuple %0d: valid %b got %h, need 1 %h",
                         n, idx_bus.out_valid, observed(), model_tuple(n));
            end
            @(negedge clk);
        end
        rst               = 1'b1;
        idx_bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        idx_bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
